pipe_id_ex: RTL

PIPE_ID_EX -- requirements
Module: pipe_id_ex

---
 rtl/pipe_id_ex_pkg.sv | 25 ++
 rtl/pipe_id_ex_if.sv | 46 ++++
 rtl/pipe_id_ex_frwd_mux.sv | 25 ++
 rtl/pipe_id_ex.sv | 87 ++++++++
 4 files changed

// File: rtl/pipe_id_ex_pkg.sv
// Shared constants for the ID/EX pipeline register: default datapath width,
// register-address width, bubble field values and operand-source encoding.
package pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  localparam logic              BUBBLE_VALID = 1'b0;
  localparam logic              BUBBLE_WEN   = 1'b0;
  localparam logic [REG_AW-1:0] BUBBLE_RD    = '0;

  typedef enum logic [1:0] {
    SEL_REG = 2'd0,
    SEL_MEM = 2'd1,
    SEL_ALU = 2'd2
  } frwd_sel_e;

  // EX result is newer than MEM result, so it wins when both flags are set.
  function automatic frwd_sel_e frwd_sel(input logic alu, input logic mem);
    if (alu)      return SEL_ALU;
    else if (mem) return SEL_MEM;
    else          return SEL_REG;
  endfunction

endpackage

// File: rtl/pipe_id_ex_if.sv
// Decode-side inputs and ID/EX outputs of the pipeline register.
// slave = the register itself, master = whoever drives decode/hazard signals.
interface pipe_id_ex_if #(
  parameter int XLEN  = pipe_pkg::XLEN_DEF,
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic              i_halt;
  logic              i_flush;
  logic              i_valid;
  logic [XLEN-1:0]   i_pc;
  logic [XLEN-1:0]   i_rs1_rdata;
  logic [XLEN-1:0]   i_rs2_rdata;
  logic [REG_AW-1:0] i_rd_waddr;
  logic              i_rd_wen;
  logic              i_frwd_alu_op1;
  logic              i_frwd_mem_op1;
  logic              i_frwd_alu_op2;
  logic              i_frwd_mem_op2;
  logic [XLEN-1:0]   i_alu_res;
  logic [XLEN-1:0]   i_mem_res;

  logic              o_valid;
  logic [XLEN-1:0]   o_pc;
  logic [XLEN-1:0]   o_op1;
  logic [XLEN-1:0]   o_op2;
  logic [REG_AW-1:0] o_rd_waddr;
  logic              o_rd_wen;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport master (
    output i_halt, i_flush, i_valid, i_pc, i_rs1_rdata, i_rs2_rdata,
           i_rd_waddr, i_rd_wen, i_frwd_alu_op1, i_frwd_mem_op1,
           i_frwd_alu_op2, i_frwd_mem_op2, i_alu_res, i_mem_res,
    input  o_valid, o_pc, o_op1, o_op2, o_rd_waddr, o_rd_wen, o_stall_cnt
  );

  modport slave (
    input  i_halt, i_flush, i_valid, i_pc, i_rs1_rdata, i_rs2_rdata,
           i_rd_waddr, i_rd_wen, i_frwd_alu_op1, i_frwd_mem_op1,
           i_frwd_alu_op2, i_frwd_mem_op2, i_alu_res, i_mem_res,
    output o_valid, o_pc, o_op1, o_op2, o_rd_waddr, o_rd_wen, o_stall_cnt
  );

endinterface

// File: rtl/pipe_id_ex_frwd_mux.sv
// Combinational 3:1 operand forwarding mux: EX result, then MEM result,
// then register-file data.
module frwd_mux
  import pipe_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic         sel_alu,
  input  logic         sel_mem,
  input  logic [W-1:0] rf,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] mem,
  output logic [W-1:0] y
);

  always_comb begin
    y = rf;
    unique case (frwd_sel(sel_alu, sel_mem))
      SEL_ALU: y = alu;
      SEL_MEM: y = mem;
      default: y = rf;
    endcase
  end

endmodule

// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register with flush/halt control and operand forwarding.
// Optional halt-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_id_ex
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pipe_id_ex_if.slave  bus
);

  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;
  logic            op1_fwd;
  logic            op2_fwd;
  logic            rd_wen_cap;

  frwd_mux #(.W(XLEN)) u_mux_op1 (
    .sel_alu (bus.i_frwd_alu_op1),
    .sel_mem (bus.i_frwd_mem_op1),
    .rf      (bus.i_rs1_rdata),
    .alu     (bus.i_alu_res),
    .mem     (bus.i_mem_res),
    .y       (op1_sel)
  );

  frwd_mux #(.W(XLEN)) u_mux_op2 (
    .sel_alu (bus.i_frwd_alu_op2),
    .sel_mem (bus.i_frwd_mem_op2),
    .rf      (bus.i_rs2_rdata),
    .alu     (bus.i_alu_res),
    .mem     (bus.i_mem_res),
    .y       (op2_sel)
  );

  assign op1_fwd    = bus.i_frwd_alu_op1 | bus.i_frwd_mem_op1;
  assign op2_fwd    = bus.i_frwd_alu_op2 | bus.i_frwd_mem_op2;
  // Writes to x0 are never architecturally visible, so drop the enable early.
  assign rd_wen_cap = bus.i_rd_wen & (bus.i_rd_waddr != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid    <= BUBBLE_VALID;
      bus.o_pc       <= '0;
      bus.o_op1      <= '0;
      bus.o_op2      <= '0;
      bus.o_rd_waddr <= BUBBLE_RD;
      bus.o_rd_wen   <= BUBBLE_WEN;
    end else if (bus.i_flush || (!bus.i_halt && !bus.i_valid)) begin
      bus.o_valid    <= BUBBLE_VALID;
      bus.o_pc       <= '0;
      bus.o_op1      <= '0;
      bus.o_op2      <= '0;
      bus.o_rd_waddr <= BUBBLE_RD;
      bus.o_rd_wen   <= BUBBLE_WEN;
    end else if (bus.i_halt) begin
      // Held instruction still needs operands that resolve while it waits.
      if (op1_fwd) bus.o_op1 <= op1_sel;
      if (op2_fwd) bus.o_op2 <= op2_sel;
    end else begin
      bus.o_valid    <= 1'b1;
      bus.o_pc       <= bus.i_pc;
      bus.o_op1      <= op1_sel;
      bus.o_op2      <= op2_sel;
      bus.o_rd_waddr <= bus.i_rd_waddr;
      bus.o_rd_wen   <= rd_wen_cap;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (bus.i_halt && !bus.i_flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.o_stall_cnt = stall_cnt;
`else
  assign bus.o_stall_cnt = '0;
`endif

endmodule
